pll_reconfig_seq: RTL and testbench

PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

---
 rtl/pll_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_reconfig_seq.sv | 186 ++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: FSM states,
// register map, STATUS bit positions and the default register-bus types.
package pll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BYPASS    = 3'd1,
        ST_PROGRAM   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    localparam logic [11:0] ADDR_CTRL     = 12'h000;
    localparam logic [11:0] ADDR_TGT_SEL  = 12'h008;
    localparam logic [11:0] ADDR_TGT_CODE = 12'h010;
    localparam logic [11:0] ADDR_STATUS   = 12'h018;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_LOCK    = 3;

    // Sized for the largest legal SETTLE_CYCLES (255) and LOCK_TIMEOUT (65535).
    localparam int SETTLE_W = 8;
    localparam int TIMER_W  = 16;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
    } pll_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] rdata;
        logic        error;
    } pll_rsp_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: bypass, settle, reprogram divider/code,
// wait for a stable lock (or time out), then release bypass.
module pll_reconfig_seq
    import pll_pkg::*;
#(
    parameter type         reg_req_t     = pll_req_t,
    parameter type         reg_rsp_t     = pll_rsp_t,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        pll_lock_i,
    output logic        bypass_o,
    output logic [2:0]  sel_o,
    output logic [11:0] code_bp_o,
    output logic        busy_o,
    output logic        irq_o,
    input  reg_req_t    req_i,
    output reg_rsp_t    rsp_o
);

    state_t              state_reg;
    logic                bypass_reg;
    logic [2:0]          sel_reg;
    logic [11:0]         code_reg;
    logic                busy_reg;
    logic                irq_reg;
    logic                done_reg;
    logic                timeout_reg;
    logic [2:0]          tgt_sel_reg;
    logic [11:0]         tgt_code_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic                lock_hist_reg;
    logic                lock_s;

    sync_2ff u_lock_sync (
        .clk  (clk_i),
        .rstn (rstn_i),
        .din  (pll_lock_i),
        .dout (lock_s)
    );

    logic [11:0] addr;
    logic [63:0] rdata;
    logic        mapped;
    logic        err;
    logic        wr_ok;
    logic        start_ok;
    logic        sel_we;
    logic        code_we;

    assign addr = req_i.addr[11:0];

    // Only the low address bits and low data bits are meaningful.
    logic unused_bits;
    assign unused_bits = ^{req_i.addr, req_i.wdata};

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (addr)
            ADDR_CTRL:     rdata = '0;
            ADDR_TGT_SEL:  rdata[2:0] = tgt_sel_reg;
            ADDR_TGT_CODE: rdata[11:0] = tgt_code_reg;
            ADDR_STATUS: begin
                rdata[STAT_BUSY]    = busy_reg;
                rdata[STAT_DONE]    = done_reg;
                rdata[STAT_TIMEOUT] = timeout_reg;
                rdata[STAT_LOCK]    = lock_s;
            end
            default:       mapped = 1'b0;
        endcase

        err = 1'b0;
        if (req_i.valid) begin
            if (!mapped) begin
                err = 1'b1;
            end else if (req_i.write) begin
                if (addr == ADDR_STATUS) begin
                    err = 1'b1;
                end else if ((addr == ADDR_TGT_SEL || addr == ADDR_TGT_CODE) && busy_reg) begin
                    err = 1'b1;
                end else if (addr == ADDR_CTRL && req_i.wdata[0] && busy_reg) begin
                    err = 1'b1;
                end
            end
        end

        wr_ok    = req_i.valid && req_i.write && !err;
        start_ok = wr_ok && (addr == ADDR_CTRL) && req_i.wdata[0];
        sel_we   = wr_ok && (addr == ADDR_TGT_SEL);
        code_we  = wr_ok && (addr == ADDR_TGT_CODE);

        rsp_o       = '0;
        rsp_o.ready = 1'b1;
        rsp_o.rdata = rdata;
        rsp_o.error = err;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg      <= ST_IDLE;
            bypass_reg     <= 1'b1;
            sel_reg        <= '0;
            code_reg       <= '0;
            busy_reg       <= 1'b0;
            irq_reg        <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            tgt_sel_reg    <= '0;
            tgt_code_reg   <= '0;
            settle_cnt_reg <= '0;
            timer_reg      <= '0;
            lock_hist_reg  <= 1'b0;
        end else begin
            irq_reg <= 1'b0;
            if (sel_we) begin
                tgt_sel_reg <= req_i.wdata[2:0];
            end
            if (code_we) begin
                tgt_code_reg <= req_i.wdata[11:0];
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        done_reg       <= 1'b0;
                        timeout_reg    <= 1'b0;
                        bypass_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
                        settle_cnt_reg <= '0;
                        state_reg      <= ST_BYPASS;
                    end
                end
                ST_BYPASS: begin
                    if (settle_cnt_reg == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        settle_cnt_reg <= '0;
                        state_reg      <= ST_PROGRAM;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                ST_PROGRAM: begin
                    sel_reg       <= tgt_sel_reg;
                    code_reg      <= tgt_code_reg;
                    timer_reg     <= '0;
                    lock_hist_reg <= 1'b0;
                    state_reg     <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    lock_hist_reg <= lock_s;
                    // Lock is tested first so a tie with the timeout counts as success.
                    if (lock_s && lock_hist_reg) begin
                        state_reg <= ST_RELEASE;
                    end else if (timer_reg == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        timeout_reg <= 1'b1;
                        irq_reg     <= 1'b1;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    bypass_reg <= 1'b0;
                    done_reg   <= 1'b1;
                    irq_reg    <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bypass_o  = bypass_reg;
    assign sel_o     = sel_reg;
    assign code_bp_o = code_reg;
    assign busy_o    = busy_reg;
    assign irq_o     = irq_reg;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: success, timeout, busy errors,
// lock glitch and mid-sequence reset, with hand-computed cycle positions.
module tb_pll_reconfig_seq;
    import pll_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pll_lock;
    logic        bypass;
    logic [2:0]  sel;
    logic [11:0] code_bp;
    logic        busy;
    logic        irq;
    pll_req_t    req;
    pll_rsp_t    rsp;

    int n_checks = 0;
    int n_errors = 0;

    logic        bypass_hist [0:127];
    logic        busy_hist   [0:127];
    logic        irq_hist    [0:127];
    logic [2:0]  sel_hist    [0:127];
    logic [11:0] code_hist   [0:127];

    always #5 clk = ~clk;

    pll_reconfig_seq #(
        .reg_req_t     (pll_req_t),
        .reg_rsp_t     (pll_rsp_t),
        .SETTLE_CYCLES (16),
        .LOCK_TIMEOUT  (64)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .pll_lock_i (pll_lock),
        .bypass_o   (bypass),
        .sel_o      (sel),
        .code_bp_o  (code_bp),
        .busy_o     (busy),
        .irq_o      (irq),
        .req_i      (req),
        .rsp_o      (rsp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er);
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = a;
        req.wdata = d;
        #1;
        rd = rsp.rdata;
        er = rsp.error;
        $display("bus %s addr=0x%03h wdata=0x%0h rdata=0x%0h error=%0b",
                 wr ? "WR" : "RD", a[11:0], d, rd, er);
        tick();
        req = '0;
    endtask

    // t=0 is the first sample after the start edge; one clock edge per t.
    task automatic run(input int n, input int on1, input int off1, input int on2, input bit poke);
        for (int t = 0; t < n; t++) begin
            bypass_hist[t] = bypass;
            busy_hist[t]   = busy;
            irq_hist[t]    = irq;
            sel_hist[t]    = sel;
            code_hist[t]   = code_bp;
            if (t == on1 || t == on2) pll_lock = 1'b1;
            if (t == off1) pll_lock = 1'b0;
            if (poke && t == 5) begin
                req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h010; req.wdata = 64'h3FF;
                #1;
                check("busy_code_write_err", rsp.error, 1'b1);
            end
            if (poke && t == 6) begin
                req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h000; req.wdata = 64'h1;
                #1;
                check("busy_start_err", rsp.error, 1'b1);
            end
            tick();
            req = '0;
        end
    endtask

    function automatic int count_ones_irq(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (irq_hist[i]) c++;
        return c;
    endfunction

    function automatic int count_low_bypass(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (!bypass_hist[i]) c++;
        return c;
    endfunction

    logic [63:0] rd;
    logic        er;

    initial begin
        rstn     = 1'b0;
        pll_lock = 1'b0;
        req      = '0;
        repeat (3) tick();
        check("rst_bypass", bypass, 1'b1);
        check("rst_sel", sel, 3'd0);
        check("rst_code", code_bp, 12'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_irq", irq, 1'b0);
        rstn = 1'b1;
        tick();
        bus(1'b0, 32'h018, 64'h0, rd, er);
        check("rst_status", rd, 64'h0);

        // Register map corner cases.
        bus(1'b0, 32'h020, 64'h0, rd, er);
        check("unmapped_err", er, 1'b1);
        bus(1'b1, 32'h018, 64'hF, rd, er);
        check("status_write_err", er, 1'b1);
        bus(1'b0, 32'h000, 64'h0, rd, er);
        check("ctrl_read", {rd[62:0], er}, 64'h0);

        // Success run.
        bus(1'b1, 32'h008, 64'h3, rd, er);
        check("sel_write_ok", er, 1'b0);
        bus(1'b1, 32'h010, 64'h0A5, rd, er);
        bus(1'b0, 32'h1008, 64'h0, rd, er);
        check("alias_sel_read", rd, 64'h3);
        bus(1'b1, 32'h000, 64'h1, rd, er);
        run(100, 40, -1, -1, 1'b0);
        check("ok_busy_t0", busy_hist[0], 1'b1);
        check("ok_sel_t16", sel_hist[16], 3'd0);
        check("ok_sel_t17", sel_hist[17], 3'd3);
        check("ok_code_t17", code_hist[17], 12'h0A5);
        check("ok_bypass_hold", count_low_bypass(45), 0);
        check("ok_bypass_t45", bypass_hist[45], 1'b0);
        check("ok_busy_t44", busy_hist[44], 1'b1);
        check("ok_busy_t45", busy_hist[45], 1'b0);
        check("ok_irq_t45", irq_hist[45], 1'b1);
        check("ok_irq_count", count_ones_irq(100), 1);
        bus(1'b0, 32'h018, 64'h0, rd, er);
        check("ok_status", rd, 64'hA);

        // Lock loss while idle leaves outputs alone.
        pll_lock = 1'b0;
        repeat (4) tick();
        check("idle_lock_loss_bypass", bypass, 1'b0);
        check("idle_lock_loss_irq", irq, 1'b0);

        // Timeout run with busy-time writes.
        bus(1'b1, 32'h000, 64'h1, rd, er);
        run(120, -1, -1, -1, 1'b1);
        check("to_bypass_hold", count_low_bypass(120), 0);
        check("to_busy_t80", busy_hist[80], 1'b1);
        check("to_busy_t81", busy_hist[81], 1'b0);
        check("to_irq_t81", irq_hist[81], 1'b1);
        check("to_irq_count", count_ones_irq(120), 1);
        check("to_code_kept", code_hist[30], 12'h0A5);
        bus(1'b0, 32'h018, 64'h0, rd, er);
        check("to_status", rd, 64'h4);
        bus(1'b0, 32'h010, 64'h0, rd, er);
        check("to_tgt_code_kept", rd, 64'h0A5);

        // One-cycle lock glitch, then stable lock.
        bus(1'b1, 32'h000, 64'h1, rd, er);
        bus(1'b0, 32'h018, 64'h0, rd, er);
        check("gl_status_busy", rd, 64'h1);
        run(80, 19, 20, 29, 1'b0);
        check("gl_bypass_t33", bypass_hist[33], 1'b1);
        check("gl_bypass_t34", bypass_hist[34], 1'b0);
        check("gl_irq_t34", irq_hist[34], 1'b1);
        check("gl_irq_count", count_ones_irq(80), 1);
        bus(1'b0, 32'h018, 64'h0, rd, er);
        check("gl_status", rd, 64'hA);

        // Reset in the middle of WAIT_LOCK.
        pll_lock = 1'b0;
        repeat (3) tick();
        bus(1'b1, 32'h000, 64'h1, rd, er);
        run(25, -1, -1, -1, 1'b0);
        check("mr_sel_before", sel, 3'd3);
        rstn = 1'b0;
        tick();
        check("mr_bypass", bypass, 1'b1);
        check("mr_sel", sel, 3'd0);
        check("mr_code", code_bp, 12'd0);
        check("mr_busy", busy, 1'b0);
        check("mr_irq", irq, 1'b0);
        tick();
        check("mr_irq_hold", irq, 1'b0);
        rstn = 1'b1;
        tick();
        check("mr_irq_after", irq, 1'b0);
        bus(1'b0, 32'h008, 64'h0, rd, er);
        check("mr_tgt_sel", rd, 64'h0);
        bus(1'b0, 32'h010, 64'h0, rd, er);
        check("mr_tgt_code", rd, 64'h0);
        bus(1'b0, 32'h018, 64'h0, rd, er);
        check("mr_status", rd, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
